pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 125 ++++++++++++
 tb/tb_pc_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch unit: requests the word at pc, registers it, and retires it
// once downstream accepts, choosing the next pc from jump / branch / sequential.
// Optional retired-instruction counter enabled by defining PC_RETIRE_CNT_EN.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel5,
   input  logic        jump,
   input  logic [31:0] imm,
   input  logic [25:0] jaddr,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] icount
);

   // state | meaning
   // IDLE  | single cycle after reset release, no request issued
   // REQ   | imem_req high at imem_addr = pc, waiting for imem_ack
   // EXEC  | instr valid; held while stall, retired when stall drops
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_r, pc_nxt;
   logic [31:0] instr_r, instr_nxt;
   logic        valid_r, valid_nxt;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign pc_plus4 = pc_r + 32'd4;
   assign br_off   = imm << 2;

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      end else if (sel5) begin
         next_pc = pc_plus4 + br_off;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_r;
      instr_nxt = instr_r;
      valid_nxt = valid_r;
      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               valid_nxt = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            // stall freezes everything; branch/jump inputs only matter on retire
            if (!stall) begin
               pc_nxt    = next_pc;
               valid_nxt = 1'b0;
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc_r    <= RESET_PC;
         instr_r <= 32'd0;
         valid_r <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_r    <= pc_nxt;
         instr_r <= instr_nxt;
         valid_r <= valid_nxt;
      end
   end

   // request and address come straight from registered state, so there is no
   // combinational path from rst_n or imem_ack to the memory port
   assign imem_req    = (state == REQ);
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign instr       = instr_r;
   assign instr_valid = valid_r;

`ifdef PC_RETIRE_CNT_EN
   logic        retire;
   logic [31:0] icount_r;

   assign retire = (state == EXEC) && !stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         icount_r <= 32'd0;
      end else if (retire) begin
         icount_r <= icount_r + 32'd1;
      end
   end

   assign icount = icount_r;
`else
   assign icount = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, reset corner cases,
// pc wrap-around, and randomized fetch/retire traffic against a reference model.
module tb_pc_fetch;

   logic        clk;
   logic        rst_n;
   logic        sel5;
   logic        jump;
   logic [31:0] imm;
   logic [25:0] jaddr;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] icount;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mpc;
   logic [31:0] mcnt;

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel5       (sel5),
      .jump       (jump),
      .imm        (imm),
      .jaddr      (jaddr),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .icount     (icount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] rdata;
      int          dly;
      int          stalls;
      bit          s5;
      bit          jp;
      logic [31:0] im;
      logic [25:0] ja;
      logic [31:0] exp_next;
   } vec_t;

   vec_t tbl[9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_icount();
`ifdef PC_RETIRE_CNT_EN
      return mcnt;
`else
      return 32'd0;
`endif
   endfunction

   // Architectural rule for the next fetch address, plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] p, input bit s5, input bit jp,
                                            input logic [31:0] im, input logic [25:0] ja);
      logic [31:0] p4;
      p4 = p + 32'd4;
      if (jp) return (p4 & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
      if (s5) return p4 + im * 32'd4;
      return p4;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; sel5 = 1'b0; jump = 1'b0;
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_icount", icount, 32'h0);
      rst_n = 1'b1;
      step();
      check("idle_one_cycle_req", {31'd0, imem_req}, 32'd1);
      mpc  = 32'h0;
      mcnt = 32'd0;
   endtask

   task automatic fetch(input logic [31:0] rdata, input int dly, input int stalls,
                        input bit s5, input bit jp, input logic [31:0] im,
                        input logic [25:0] ja, input logic [31:0] exp_next);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         step();
         n++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
      check("imem_addr", imem_addr, mpc);
      check("pc_at_req", pc, mpc);
      check("pc_plus4", pc_plus4, mpc + 32'd4);
      for (int i = 0; i < dly; i++) begin
         imem_rdata = $urandom;
         step();
         check("req_hold", {31'd0, imem_req}, 32'd1);
         check("addr_hold", imem_addr, mpc);
      end
      imem_ack = 1'b1; imem_rdata = rdata;
      step();
      imem_ack = 1'b0; imem_rdata = $urandom;
      check("instr_loaded", instr, rdata);
      check("valid_set", {31'd0, instr_valid}, 32'd1);
      check("req_drop", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < stalls; i++) begin
         stall = 1'b1; sel5 = $urandom_range(1); jump = $urandom_range(1);
         imem_ack = $urandom_range(1); imem_rdata = $urandom;
         step();
         check("stall_pc", pc, mpc);
         check("stall_instr", instr, rdata);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0; imem_ack = 1'b0;
      sel5 = s5; jump = jp; imm = im; jaddr = ja;
      step();
      sel5 = 1'b0; jump = 1'b0;
      mpc = exp_next;
      mcnt = mcnt + 32'd1;
      check("retire_pc", pc, mpc);
      check("retire_valid", {31'd0, instr_valid}, 32'd0);
      check("retire_req", {31'd0, imem_req}, 32'd1);
      check("icount", icount, exp_icount());
   endtask

   initial begin
      rst_n = 1'b0; sel5 = 1'b0; jump = 1'b0; imm = 32'd0; jaddr = 26'd0;
      stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
      mpc = 32'd0; mcnt = 32'd0;

      tbl[0] = '{32'h1234_5678, 2, 0, 1'b0, 1'b0, 32'h0000_0000, 26'h000_0000, 32'h0000_0004};
      tbl[1] = '{32'hA5A5_0001, 0, 1, 1'b1, 1'b0, 32'h0000_0003, 26'h000_0000, 32'h0000_0014};
      tbl[2] = '{32'hA5A5_0002, 1, 0, 1'b0, 1'b1, 32'h0000_0000, 26'h000_0040, 32'h0000_0100};
      tbl[3] = '{32'hA5A5_0003, 3, 2, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h000_0000, 32'h0000_00FC};
      tbl[4] = '{32'hA5A5_0004, 0, 5, 1'b0, 1'b0, 32'h0000_0000, 26'h000_0000, 32'h0000_0100};
      tbl[5] = '{32'hA5A5_0005, 1, 0, 1'b1, 1'b1, 32'h0000_0010, 26'h3FF_FFFF, 32'h0FFF_FFFC};
      tbl[6] = '{32'hA5A5_0006, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 26'h000_0000, 32'h1000_0000};
      tbl[7] = '{32'hA5A5_0007, 2, 1, 1'b1, 1'b1, 32'h0000_0007, 26'h000_0040, 32'h1000_0100};
      tbl[8] = '{32'hA5A5_0008, 0, 0, 1'b1, 1'b0, 32'h3BFF_FFC0, 26'h000_0000, 32'h0000_0004};

      step();
      do_reset();
      for (int v = 0; v < 9; v++) begin
         fetch(tbl[v].rdata, tbl[v].dly, tbl[v].stalls, tbl[v].s5, tbl[v].jp,
               tbl[v].im, tbl[v].ja, tbl[v].exp_next);
      end

      // reset colliding with an ack while the request is outstanding
      do_reset();
      step();
      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      check("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_ack_instr", instr, 32'h0);
      check("rst_ack_pc", pc, 32'h0);
      check("rst_ack_req", {31'd0, imem_req}, 32'd0);
      rst_n = 1'b1;
      step();
      mpc = 32'h0; mcnt = 32'd0;

      // reset in the middle of a stall
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
      step();
      imem_ack = 1'b0; stall = 1'b1;
      step();
      rst_n = 1'b0;
      step();
      check("rst_stall_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_stall_instr", instr, 32'h0);
      check("rst_stall_icount", icount, 32'h0);
      stall = 1'b0;
      do_reset();

      // branch to the top of the address space, then walk sequentially through 0
      fetch(32'h1111_0000, 0, 0, 1'b1, 1'b0, 32'h3FFF_FFFD, 26'h0, 32'hFFFF_FFF8);
      for (int k = 0; k < 10; k++) begin
         fetch(32'h2222_0000 + k, $urandom_range(2), 0, 1'b0, 1'b0, 32'h0, 26'h0, mpc + 32'd4);
      end
      check("wrap_pc", pc, 32'h0000_0020);
      check("wrap_icount", icount,
`ifdef PC_RETIRE_CNT_EN
            32'd11
`else
            32'd0
`endif
      );

      // randomized traffic against the reference next-pc rule
      for (int r = 0; r < 40; r++) begin
         logic [31:0] rim;
         logic [25:0] rja;
         bit          rs5, rjp;
         rim = ($urandom_range(1) == 1) ? $urandom : ($urandom_range(64) - 32);
         rja = 26'($urandom);
         rs5 = $urandom_range(1);
         rjp = ($urandom_range(3) == 0);
         fetch($urandom, $urandom_range(3), $urandom_range(3), rs5, rjp, rim, rja,
               ref_next(mpc, rs5, rjp, rim, rja));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
